// File: rtl/axi4_lite_cmd_arbiter_if.sv
// Bundle of signals between the two requesters, the arbiter and the
// AXI4-Lite master command port.
//   m0_* / m1_* : requester side (req/write/addr/wdata in, ack/rdata/err out)
//   read_s, write_s, address, W_data : start strobes and command to the master
//   txn_done, txn_rdata, txn_resp    : completion returned by the master
// modport master : arbiter view (drives strobes/command and requester acks)
// modport slave  : environment view (drives requests and master completion)
interface axi4_lite_cmd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_write;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;

  logic              m1_req;
  logic              m1_write;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  logic              read_s;
  logic              write_s;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] W_data;
  logic              txn_done;
  logic [DATA_W-1:0] txn_rdata;
  logic [1:0]        txn_resp;

  modport master (
    input  m0_req, m0_write, m0_addr, m0_wdata,
    output m0_ack, m0_rdata, m0_err,
    input  m1_req, m1_write, m1_addr, m1_wdata,
    output m1_ack, m1_rdata, m1_err,
    output read_s, write_s, address, W_data,
    input  txn_done, txn_rdata, txn_resp
  );

  modport slave (
    output m0_req, m0_write, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata, m0_err,
    output m1_req, m1_write, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata, m1_err,
    input  read_s, write_s, address, W_data,
    output txn_done, txn_rdata, txn_resp
  );
endinterface

// File: rtl/axi4_lite_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master command port between two
// requesters. One transaction at a time: grant, one-cycle start strobe, wait
// for completion (with optional timeout), one-cycle ack back to the requester.
// Ports:
//   ACLK    : clock, rising edge
//   ARESETN : asynchronous active-low reset
//   bus     : axi4_lite_cmd_arbiter_if.master (requesters + master command port)
module axi4_lite_cmd_arbiter #(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                      ACLK,
  input logic                      ARESETN,
  axi4_lite_cmd_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  state_t            state, state_nxt;
  logic              rr;          // preferred requester when both request
  logic              gnt;         // index of the requester being served
  logic              wr_lat;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] wdata_lat;
  logic [31:0]       tmo_cnt;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              err0, err1;

  logic              any_req;
  logic              grant_sel;
  logic              tmo_hit;
  logic              cap_en;
  logic [DATA_W-1:0] cap_rdata;
  logic              cap_err;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != 2'b00;
  endfunction

  assign any_req   = bus.m0_req | bus.m1_req;
  assign grant_sel = (bus.m0_req && bus.m1_req) ? rr : bus.m1_req;
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
  assign cap_en    = (state == WAIT) && (bus.txn_done || tmo_hit);

  // Completion wins over a timeout landing on the same cycle.
  always_comb begin
    cap_rdata = '0;
    cap_err   = 1'b1;
    if (bus.txn_done) begin
      cap_rdata = wr_lat ? '0 : bus.txn_rdata;
      cap_err   = resp_is_err(bus.txn_resp);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.txn_done || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, request latch, timeout counter and response capture
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      rr        <= 1'b0;
      gnt       <= 1'b0;
      wr_lat    <= 1'b0;
      addr_lat  <= '0;
      wdata_lat <= '0;
      tmo_cnt   <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
      err0      <= 1'b0;
      err1      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt       <= grant_sel;
            wr_lat    <= grant_sel ? bus.m1_write : bus.m0_write;
            addr_lat  <= grant_sel ? bus.m1_addr  : bus.m0_addr;
            wdata_lat <= grant_sel ? bus.m1_wdata : bus.m0_wdata;
          end
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          if (cap_en) begin
            if (gnt) begin
              rdata1 <= cap_rdata;
              err1   <= cap_err;
            end else begin
              rdata0 <= cap_rdata;
              err0   <= cap_err;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        RESP: rr <= ~gnt;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so reset forces them low immediately
  assign bus.read_s   = (state == ISSUE) && !wr_lat;
  assign bus.write_s  = (state == ISSUE) && wr_lat;
  assign bus.address  = (state == ISSUE || state == WAIT) ? addr_lat : '0;
  assign bus.W_data   = ((state == ISSUE || state == WAIT) && wr_lat) ? wdata_lat : '0;
  assign bus.m0_ack   = (state == RESP) && !gnt;
  assign bus.m1_ack   = (state == RESP) && gnt;
  assign bus.m0_rdata = rdata0;
  assign bus.m0_err   = err0;
  assign bus.m1_rdata = rdata1;
  assign bus.m1_err   = err1;

endmodule

// File: tb/tb_axi4_lite_cmd_arbiter.sv
module tb_axi4_lite_cmd_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi4_lite_cmd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi4_lite_cmd_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .ACLK(clk), .ARESETN(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_err = 0;
  int rr_m = 0;
  logic [31:0] held_rd [2];
  logic        held_err [2];

  typedef struct {
    logic q0, q1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    int dly;                 // WAIT cycle index of txn_done, -1 = never
    logic [31:0] rd;
    logic [1:0] rsp;
    int eg;
    logic [31:0] erd;
    logic eerr;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, " read_s"}, 64'(bus.read_s), 64'd0);
    check({nm, " write_s"}, 64'(bus.write_s), 64'd0);
    check({nm, " address"}, 64'(bus.address), 64'd0);
    check({nm, " W_data"}, 64'(bus.W_data), 64'd0);
    check({nm, " acks"}, 64'({bus.m0_ack, bus.m1_ack}), 64'd0);
  endtask

  task automatic clear_model();
    rr_m = 0;
    for (int i = 0; i < 2; i++) begin
      held_rd[i] = '0;
      held_err[i] = 1'b0;
    end
  endtask

  // Entered at posedge+1 with the DUT in IDLE; leaves it in IDLE.
  task automatic run_txn(input string nm, input vec_t v);
    logic ew;
    logic [31:0] ea, ed;
    int nwait, og;
    ew = v.eg ? v.w1 : v.w0;
    ea = v.eg ? v.a1 : v.a0;
    ed = ew ? (v.eg ? v.d1 : v.d0) : 32'd0;
    nwait = (v.dly >= 0 && v.dly < TO) ? v.dly + 1 : TO;
    og = 1 - v.eg;
    bus.m0_req = v.q0; bus.m0_write = v.w0; bus.m0_addr = v.a0; bus.m0_wdata = v.d0;
    bus.m1_req = v.q1; bus.m1_write = v.w1; bus.m1_addr = v.a1; bus.m1_wdata = v.d1;
    step();
    check({nm, " write_s"}, 64'(bus.write_s), 64'(ew));
    check({nm, " read_s"}, 64'(bus.read_s), 64'(!ew));
    check({nm, " issue address"}, 64'(bus.address), 64'(ea));
    check({nm, " issue W_data"}, 64'(bus.W_data), 64'(ed));
    // Requests and fields change after grant; transaction must be unaffected.
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    bus.m0_write = 1'($urandom); bus.m1_write = 1'($urandom);
    bus.m0_addr = $urandom; bus.m1_addr = $urandom;
    bus.m0_wdata = $urandom; bus.m1_wdata = $urandom;
    for (int w = 0; w < nwait; w++) begin
      step();
      bus.txn_done = 1'b0;
      check($sformatf("%s wait%0d strobes", nm, w), 64'({bus.read_s, bus.write_s}), 64'd0);
      check($sformatf("%s wait%0d acks", nm, w), 64'({bus.m0_ack, bus.m1_ack}), 64'd0);
      check($sformatf("%s wait%0d address", nm, w), 64'(bus.address), 64'(ea));
      check($sformatf("%s wait%0d W_data", nm, w), 64'(bus.W_data), 64'(ed));
      if (w == v.dly) begin
        bus.txn_done = 1'b1; bus.txn_rdata = v.rd; bus.txn_resp = v.rsp;
      end
    end
    step();
    bus.txn_done = 1'b0; bus.txn_rdata = $urandom; bus.txn_resp = 2'($urandom);
    check({nm, " m0_ack"}, 64'(bus.m0_ack), 64'(v.eg == 0));
    check({nm, " m1_ack"}, 64'(bus.m1_ack), 64'(v.eg == 1));
    check({nm, " rdata"}, 64'(v.eg ? bus.m1_rdata : bus.m0_rdata), 64'(v.erd));
    check({nm, " err"}, 64'(v.eg ? bus.m1_err : bus.m0_err), 64'(v.eerr));
    check({nm, " other rdata held"}, 64'(og ? bus.m1_rdata : bus.m0_rdata), 64'(held_rd[og]));
    check({nm, " other err held"}, 64'(og ? bus.m1_err : bus.m0_err), 64'(held_err[og]));
    held_rd[v.eg] = v.erd;
    held_err[v.eg] = v.eerr;
    rr_m = og;
    step();
    check_idle_outputs({nm, " idle"});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    clear_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int acks_seen;
    int order [4];
    logic strobe_flag;

    tbl[0] = '{1,0,1,0, 32'd5, 32'd0, 32'd4, 32'd0, 1, 32'hFFFF_FFFF, 2'b00, 0, 32'd0, 1'b0};
    tbl[1] = '{0,1,0,0, 32'd0, 32'd5, 32'd0, 32'd0, 0, 32'h0000_0004, 2'b00, 1, 32'd4, 1'b0};
    tbl[2] = '{1,1,1,0, 32'h100, 32'h200, 32'h11, 32'h22, 0, 32'hAAAA, 2'b00, 0, 32'd0, 1'b0};
    tbl[3] = '{1,1,1,0, 32'h100, 32'h200, 32'h11, 32'h22, 0, 32'hBBBB, 2'b00, 1, 32'hBBBB, 1'b0};
    tbl[4] = '{1,1,1,0, 32'h104, 32'h204, 32'h33, 32'h44, 2, 32'hCCCC, 2'b00, 0, 32'd0, 1'b0};
    tbl[5] = '{1,1,1,0, 32'h104, 32'h204, 32'h33, 32'h44, 2, 32'hDDDD, 2'b00, 1, 32'hDDDD, 1'b0};
    tbl[6] = '{1,0,0,0, 32'h30, 32'd0, 32'h99, 32'd0, 3, 32'hDEAD_BEEF, 2'b10, 0, 32'hDEAD_BEEF, 1'b1};
    tbl[7] = '{0,1,0,0, 32'd0, 32'h40, 32'd0, 32'h77, -1, 32'h1111, 2'b00, 1, 32'd0, 1'b1};
    tbl[8] = '{1,0,1,0, 32'h50, 32'd0, 32'h5A5A, 32'd0, 2, 32'h5555, 2'b01, 0, 32'd0, 1'b1};
    tbl[9] = '{1,1,1,0, 32'h60, 32'h70, 32'h1, 32'h2, TO - 1, 32'h1234, 2'b00, 1, 32'h1234, 1'b0};

    rst_n = 1'b0;
    bus.m0_req = 0; bus.m0_write = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_write = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.txn_done = 0; bus.txn_rdata = '0; bus.txn_resp = '0;
    #1;
    check_idle_outputs("reset");
    check("reset rdata/err", 64'({bus.m0_rdata, bus.m0_err, bus.m1_err}), 64'd0);
    check("reset m1_rdata", 64'(bus.m1_rdata), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    clear_model();

    for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Completion outside WAIT must be ignored.
    bus.txn_done = 1'b1; bus.txn_resp = 2'b10; bus.txn_rdata = 32'hFEED;
    step();
    bus.txn_done = 1'b0;
    check_idle_outputs("stray done 1");
    step();
    check_idle_outputs("stray done 2");
    check("stray done m1_rdata", 64'(bus.m1_rdata), 64'(held_rd[1]));

    // Both requesters hold req continuously from reset: grants must alternate.
    do_reset();
    bus.m0_req = 1; bus.m0_write = 0; bus.m0_addr = 32'h10;
    bus.m1_req = 1; bus.m1_write = 0; bus.m1_addr = 32'h20;
    bus.txn_rdata = '0; bus.txn_resp = 2'b00;
    acks_seen = 0;
    strobe_flag = 1'b0;
    for (int c = 0; c < 60 && acks_seen < 4; c++) begin
      step();
      bus.txn_done = 1'b0;
      if (bus.read_s && bus.write_s) check("alt both strobes", 64'd1, 64'd0);
      if (bus.m0_ack && bus.m1_ack) check("alt both acks", 64'd1, 64'd0);
      if (strobe_flag) begin
        bus.txn_done = 1'b1;
        strobe_flag = 1'b0;
      end
      if (bus.read_s || bus.write_s) strobe_flag = 1'b1;
      if (bus.m0_ack || bus.m1_ack) begin
        order[acks_seen] = bus.m1_ack ? 1 : 0;
        acks_seen++;
        if (acks_seen == 4) begin
          bus.m0_req = 0; bus.m1_req = 0;
        end
      end
    end
    check("alt ack count", 64'(acks_seen), 64'd4);
    for (int i = 0; i < acks_seen; i++)
      check($sformatf("alt grant%0d", i), 64'(order[i]), 64'(i % 2));
    step();
    step();
    check_idle_outputs("alt end");
    rr_m = 0;

    // Reset during WAIT: everything drops at once, no ack, m1 served next.
    bus.m0_req = 1; bus.m0_write = 0; bus.m0_addr = 32'h77;
    bus.m1_req = 1; bus.m1_write = 0; bus.m1_addr = 32'h88;
    step();
    check("rst seq m0 granted addr", 64'(bus.address), 64'h77);
    step();
    step();
    bus.m0_req = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async reset");
    check("async reset rdata", 64'({bus.m0_rdata, bus.m1_rdata}), 64'd0);
    step();
    check("reset held no ack", 64'({bus.m0_ack, bus.m1_ack}), 64'd0);
    rst_n = 1'b1;
    clear_model();
    v = '{0,1,0,0, 32'h0, 32'h88, 32'h0, 32'h0, 0, 32'h4242, 2'b00, 1, 32'h4242, 1'b0};
    run_txn("after reset", v);

    // Randomised transactions against a rule-level model.
    for (int i = 0; i < 40; i++) begin
      logic ew, tmo;
      int g;
      v.q0 = 1'($urandom); v.q1 = 1'($urandom);
      if (!v.q0 && !v.q1) v.q0 = 1'b1;
      v.w0 = 1'($urandom); v.w1 = 1'($urandom);
      v.a0 = $urandom; v.a1 = $urandom; v.d0 = $urandom; v.d1 = $urandom;
      v.dly = $urandom_range(0, 10) - 1;
      v.rd = $urandom;
      v.rsp = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
      g = (v.q0 && v.q1) ? rr_m : (v.q1 ? 1 : 0);
      ew = g ? v.w1 : v.w0;
      tmo = !(v.dly >= 0 && v.dly < TO);
      v.eg = g;
      v.erd = (ew || tmo) ? 32'd0 : v.rd;
      v.eerr = tmo || (v.rsp != 2'b00);
      run_txn($sformatf("rnd%0d", i), v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
